// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter that shares one ripple-carry add/subtract
// unit among N requesters. One operation is in flight at a time: a request is
// accepted in IDLE, executed in EXEC and presented on the response channel in
// RESP until the consumer takes it.
module addsub_arbiter #(
  parameter  int B = 8,
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*B-1:0] req_x,
  input  logic [N*B-1:0] req_y,
  input  logic [N-1:0]   req_add_n,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_id,
  output logic [B-1:0]   rsp_s,
  output logic           rsp_c_out,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [W:0]   N_L      = (W+1)'(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] ONE_IDX  = W'(1);

  // Shared ripple-carry adder. Subtraction inverts y and injects add_n as the
  // carry-in, so c_out=1 on subtract means "no borrow".
  function automatic logic [B:0] ripple_addsub(input logic [B-1:0] x,
                                               input logic [B-1:0] y,
                                               input logic         add_n);
    logic [B-1:0] y_eff;
    logic [B-1:0] sum;
    logic [B:0]   carry;
    y_eff    = y ^ {B{add_n}};
    sum      = {B{1'b0}};
    carry    = {(B+1){1'b0}};
    carry[0] = add_n;
    for (int k = 0; k < B; k++) begin
      sum[k]     = x[k] ^ y_eff[k] ^ carry[k];
      carry[k+1] = (x[k] & y_eff[k]) | (carry[k] & (x[k] ^ y_eff[k]));
    end
    return {carry[B], sum};
  endfunction

  state_t         state_r;
  logic [W-1:0]   ptr_r;
  logic [B-1:0]   op_x_r;
  logic [B-1:0]   op_y_r;
  logic           op_add_n_r;
  logic [W-1:0]   op_id_r;
  logic           rsp_valid_r;
  logic [W-1:0]   rsp_id_r;
  logic [B-1:0]   rsp_s_r;
  logic           rsp_c_out_r;
  logic           busy_r;

  logic           grant_found_s;
  logic [W-1:0]   grant_idx_s;
  logic [W:0]     cand_s;
  logic [W-1:0]   ptr_next_s;
  logic [B-1:0]   add_s_s;
  logic           add_c_s;

  // Round-robin search: first valid requester at or after ptr, wrapping at N-1.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {W{1'b0}};
    cand_s        = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_r} + i[W:0];
      if (cand_s >= N_L) begin
        cand_s = cand_s - N_L;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer moves just past the granted requester so it has lowest priority next.
  always_comb begin
    if (grant_idx_s == LAST_IDX) begin
      ptr_next_s = {W{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + ONE_IDX;
    end
  end

  // One-hot accept, only in IDLE and never while reset is applied.
  always_comb begin
    req_ready = {N{1'b0}};
    if (!rst && (state_r == ST_IDLE) && grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {N{1'b0}};
    end
  end

  // Shared adder fed only from the captured operand registers.
  always_comb begin
    {add_c_s, add_s_s} = ripple_addsub(op_x_r, op_y_r, op_add_n_r);
  end

  // Sequencer FSM: accept, execute, hold the response until it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {W{1'b0}};
      op_x_r      <= {B{1'b0}};
      op_y_r      <= {B{1'b0}};
      op_add_n_r  <= 1'b0;
      op_id_r     <= {W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {W{1'b0}};
      rsp_s_r     <= {B{1'b0}};
      rsp_c_out_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            op_x_r     <= req_x[grant_idx_s*B +: B];
            op_y_r     <= req_y[grant_idx_s*B +: B];
            op_add_n_r <= req_add_n[grant_idx_s];
            op_id_r    <= grant_idx_s;
            ptr_r      <= ptr_next_s;
            busy_r     <= 1'b1;
            state_r    <= ST_EXEC;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_s_r     <= add_s_s;
          rsp_c_out_r <= add_c_s;
          rsp_id_r    <= op_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_s     = rsp_s_r;
  assign rsp_c_out = rsp_c_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (B=8, N=4) with hand-computed results.
module tb_addsub_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_add_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_s;
  logic        rsp_c_out;
  logic        busy;

  int checks;
  int errors;

  logic [7:0] rr_s [4];
  logic       rr_c [4];

  addsub_arbiter #(.B(8), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_add_n (req_add_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_c_out (rsp_c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic an);
    req_x[i*8 +: 8] = x;
    req_y[i*8 +: 8] = y;
    req_add_n[i]    = an;
  endtask

  // One full transaction: wait for a grant, follow EXEC and RESP, optional stall.
  task automatic run_op(input int exp_g, input logic [7:0] exp_s, input logic exp_c,
                        input int stall, input bit drop);
    int g;
    bit found;
    g = -1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (req_ready != 4'b0000) begin
        found = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (req_ready[i]) g = i;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      check_eq("grant_timeout", 32'd0, 32'd1);
      return;
    end
    check_eq("grant_id", g, exp_g);
    check_eq("ready_onehot", $countones(req_ready), 32'd1);
    @(posedge clk); #1;
    if (drop) req_valid[g] = 1'b0;
    check_eq("exec_busy", busy, 32'd1);
    check_eq("exec_rsp_valid", rsp_valid, 32'd0);
    check_eq("exec_ready", req_ready, 32'd0);
    @(posedge clk); #1;
    check_eq("rsp_valid", rsp_valid, 32'd1);
    check_eq("rsp_id", rsp_id, exp_g);
    check_eq("rsp_s", rsp_s, exp_s);
    check_eq("rsp_c_out", rsp_c_out, exp_c);
    check_eq("rsp_busy", busy, 32'd1);
    if (stall > 0) begin
      rsp_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check_eq("stall_valid", rsp_valid, 32'd1);
        check_eq("stall_s", rsp_s, exp_s);
        check_eq("stall_id", rsp_id, exp_g);
        check_eq("stall_c_out", rsp_c_out, exp_c);
        check_eq("stall_ready", req_ready, 32'd0);
        check_eq("stall_busy", busy, 32'd1);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("done_valid", rsp_valid, 32'd0);
    check_eq("done_busy", busy, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_x     = 32'h0;
    req_y     = 32'h0;
    req_add_n = 4'b0000;
    rr_s = '{8'h1E, 8'h00, 8'hF0, 8'h00};
    rr_c = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state, with requests pending to show req_ready held low.
    repeat (2) @(negedge clk);
    check_eq("reset_ready", req_ready, 32'd0);
    check_eq("reset_rsp_valid", rsp_valid, 32'd0);
    check_eq("reset_busy", busy, 32'd0);
    check_eq("reset_rsp_id", rsp_id, 32'd0);
    check_eq("reset_rsp_s", rsp_s, 32'd0);
    check_eq("reset_rsp_c_out", rsp_c_out, 32'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", req_ready, 32'd0);

    // Single add with overflow.
    set_req(0, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0001;
    run_op(0, 8'h00, 1'b1, 0, 1'b1);

    // Subtracts: no borrow, then borrow.
    set_req(2, 8'h05, 8'h03, 1'b1);
    req_valid = 4'b0100;
    run_op(2, 8'h02, 1'b1, 0, 1'b1);
    set_req(2, 8'h03, 8'h05, 1'b1);
    req_valid = 4'b0100;
    run_op(2, 8'hFE, 1'b0, 0, 1'b1);

    // Round-robin with all requesters continuously valid from reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_req(0, 8'h0A, 8'h14, 1'b0);
    set_req(1, 8'h80, 8'h80, 1'b0);
    set_req(2, 8'h10, 8'h20, 1'b1);
    set_req(3, 8'h50, 8'h50, 1'b1);
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      run_op(n % 4, rr_s[n % 4], rr_c[n % 4], 0, 1'b0);
    end

    // Wrap and fairness: ptr=0 after grant to 3.
    req_valid = 4'b1010;
    run_op(1, 8'h00, 1'b1, 0, 1'b1);
    run_op(3, 8'h00, 1'b1, 0, 1'b1);
    req_valid = 4'b0001;
    run_op(0, 8'h1E, 1'b0, 0, 1'b1);
    req_valid = 4'b0100;
    run_op(2, 8'hF0, 1'b0, 0, 1'b1);
    req_valid = 4'b0001;
    run_op(0, 8'h1E, 1'b0, 0, 1'b1);
    req_valid = 4'b0011;
    run_op(1, 8'h00, 1'b1, 0, 1'b1);
    req_valid = 4'b0000;

    // Backpressure: 5 stall cycles, a waiting requester must not be accepted.
    set_req(3, 8'hC8, 8'h64, 1'b0);
    set_req(0, 8'h01, 8'h02, 1'b1);
    req_valid = 4'b1001;
    run_op(3, 8'h2C, 1'b1, 5, 1'b1);
    check_eq("bp_next_ready", req_ready, 32'h1);
    run_op(0, 8'hFF, 1'b0, 0, 1'b1);

    // Async reset in the middle of EXEC.
    req_valid = 4'b0010;
    #1;
    check_eq("pre_rst_ready", req_ready, 32'h2);
    @(posedge clk); #1;
    check_eq("pre_rst_busy", busy, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_ready", req_ready, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("no_stale_valid", rsp_valid, 32'd0);
      check_eq("no_stale_busy", busy, 32'd0);
    end
    set_req(0, 8'h0A, 8'h14, 1'b0);
    req_valid = 4'b0011;
    run_op(0, 8'h1E, 1'b0, 0, 1'b1);
    run_op(1, 8'h00, 1'b1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
